io_n_bidirectional_debounce: RTL

//  N-channel bidirectional IO BEL for W/E IO tiles. Per channel: fabric->pad data/tristate path, optionally registered;
//  pad->fabric path with 2-FF synchroniser, optional inversion, optional debounce filter and a one-cycle edge pulse.
//  Per-channel mode comes from frame-config bits. Pad-side ports go to top level. Fabric-side ports go to the switch matrix.

---
 rtl/io_n_bidirectional_debounce_pkg.sv | 28 ++
 rtl/io_n_bidirectional_debounce_if.sv | 30 +++
 rtl/io_n_bidirectional_debounce_channel.sv | 86 ++++++++
 rtl/io_n_bidirectional_debounce.sv | 46 ++++
 4 files changed

// File: rtl/io_n_bidirectional_debounce_pkg.sv
// Shared definitions for the N-channel bidirectional IO BEL.
// Provides the per-channel config bit positions, a decoded config struct
// and a helper that turns a raw 4-bit config slice into that struct.
package io_n_bidirectional_debounce_pkg;

  localparam int unsigned CFG_OREG        = 0;
  localparam int unsigned CFG_INV         = 1;
  localparam int unsigned CFG_DB_EN       = 2;
  localparam int unsigned CFG_EDGE_EN     = 3;
  localparam int unsigned CFG_BITS_PER_CH = 4;

  typedef struct packed {
    logic edge_en;
    logic db_en;
    logic inv;
    logic oreg;
  } ch_cfg_t;

  function automatic ch_cfg_t decode_cfg(input logic [CFG_BITS_PER_CH-1:0] bits);
    ch_cfg_t cfg;
    cfg.oreg    = bits[CFG_OREG];
    cfg.inv     = bits[CFG_INV];
    cfg.db_en   = bits[CFG_DB_EN];
    cfg.edge_en = bits[CFG_EDGE_EN];
    return cfg;
  endfunction

endpackage

// File: rtl/io_n_bidirectional_debounce_if.sv
// Fabric/pad signal bundle for the N-channel bidirectional IO BEL.
// slave  : the BEL side (drives O, Q, EDGE, I_top, T_top).
// master : the fabric/pad side (drives I, T, O_top, ConfigBits).
interface io_n_bidirectional_debounce_if
  import io_n_bidirectional_debounce_pkg::*;
#(
  parameter int unsigned NUM_CH = 2
);

  logic [NUM_CH-1:0]                 I;
  logic [NUM_CH-1:0]                 T;
  logic [NUM_CH-1:0]                 O;
  logic [NUM_CH-1:0]                 Q;
  logic [NUM_CH-1:0]                 EDGE;
  logic [NUM_CH-1:0]                 I_top;
  logic [NUM_CH-1:0]                 T_top;
  logic [NUM_CH-1:0]                 O_top;
  logic [CFG_BITS_PER_CH*NUM_CH-1:0] ConfigBits;

  modport slave (
    input  I, T, O_top, ConfigBits,
    output O, Q, EDGE, I_top, T_top
  );

  modport master (
    output I, T, O_top, ConfigBits,
    input  O, Q, EDGE, I_top, T_top
  );

endinterface

// File: rtl/io_n_bidirectional_debounce_channel.sv
// One bidirectional IO channel.
// Ports:
//   UserCLK  fabric clock;  RST  async active-high reset
//   cfg_i    decoded channel config (oreg, inv, db_en, edge_en)
//   i_i/t_i  fabric data / tristate (1 = released)
//   pad_i    pad input, asynchronous to UserCLK
//   o_o      pad ^ inv, combinational
//   q_o      synchronised, optionally debounced, registered input
//   edge_o   one-cycle pulse on each q_o transition
//   i_top_o  pad data;  t_top_o  pad drive enable (1 = drive)
module io_n_bidirectional_debounce_channel
  import io_n_bidirectional_debounce_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 4
) (
  input  logic    UserCLK,
  input  logic    RST,
  input  ch_cfg_t cfg_i,
  input  logic    i_i,
  input  logic    t_i,
  input  logic    pad_i,
  output logic    o_o,
  output logic    q_o,
  output logic    edge_o,
  output logic    i_top_o,
  output logic    t_top_o
);

  localparam int unsigned     CntW    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(DEBOUNCE_CYCLES - 1);

  logic            sync1_q, sync2_q;
  logic            q_q, q_d;
  logic            edge_q, edge_d;
  logic            i_reg_q, t_reg_q;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            s;

  always_ff @(posedge UserCLK or posedge RST) begin
    if (RST) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      q_q     <= 1'b0;
      edge_q  <= 1'b0;
      cnt_q   <= '0;
      i_reg_q <= 1'b0;
      t_reg_q <= 1'b0;
    end else begin
      sync1_q <= pad_i;
      sync2_q <= sync1_q;
      q_q     <= q_d;
      edge_q  <= edge_d;
      cnt_q   <= cnt_d;
      i_reg_q <= i_i;
      t_reg_q <= ~t_i;
    end
  end

  // Inversion applied after the synchroniser, so an inv change looks like an input change.
  assign s = sync2_q ^ cfg_i.inv;

  always_comb begin
    q_d   = q_q;
    cnt_d = '0;
    if (!cfg_i.db_en) begin
      q_d = s;
    end else if (s != q_q) begin
      // Counter tops out at DEBOUNCE_CYCLES-1 and clears on the flip, so it never wraps.
      if (cnt_q == CntLast) begin
        q_d = s;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
    edge_d = cfg_i.edge_en & (q_d != q_q);
  end

  always_comb begin
    o_o     = pad_i ^ cfg_i.inv;
    q_o     = q_q;
    edge_o  = edge_q;
    i_top_o = cfg_i.oreg ? i_reg_q : i_i;
    t_top_o = cfg_i.oreg ? t_reg_q : ~t_i;
  end

endmodule

// File: rtl/io_n_bidirectional_debounce.sv
// N-channel bidirectional IO BEL for W/E IO tiles.
// Ports:
//   UserCLK  fabric user clock (shared, external)
//   RST      asynchronous active-high reset
//   bus      slave side of io_n_bidirectional_debounce_if:
//            I, T, ConfigBits from fabric; O, Q, EDGE to fabric;
//            I_top, T_top to pad; O_top from pad (external)
// Each channel takes 4 config bits: b0 OREG, b1 INV, b2 DB_EN, b3 EDGE_EN.
module io_n_bidirectional_debounce
  import io_n_bidirectional_debounce_pkg::*;
#(
  parameter int unsigned NUM_CH          = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 4
) (
  (* FABulous, EXTERNAL, SHARED_PORT *) input logic UserCLK,
  input logic                                       RST,
  io_n_bidirectional_debounce_if.slave              bus
);

  localparam int unsigned NoConfigBits = CFG_BITS_PER_CH * NUM_CH;

  logic [NoConfigBits-1:0] cfg_bits;
  assign cfg_bits = bus.ConfigBits;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    ch_cfg_t cfg;
    assign cfg = decode_cfg(cfg_bits[c*CFG_BITS_PER_CH +: CFG_BITS_PER_CH]);

    io_n_bidirectional_debounce_channel #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_ch (
      .UserCLK(UserCLK),
      .RST    (RST),
      .cfg_i  (cfg),
      .i_i    (bus.I[c]),
      .t_i    (bus.T[c]),
      .pad_i  (bus.O_top[c]),
      .o_o    (bus.O[c]),
      .q_o    (bus.Q[c]),
      .edge_o (bus.EDGE[c]),
      .i_top_o(bus.I_top[c]),
      .t_top_o(bus.T_top[c])
    );
  end

endmodule
